// File: rtl/dbg_snapshot_pkg.sv
// rtl/dbg_snapshot_pkg.sv - shared types and constants for the snapshot streamer
package dbg_snapshot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_REG_RD,
    ST_REG_OUT,
    ST_MEM_RD,
    ST_MEM_OUT
  } state_e;

  localparam logic [7:0] SNAP_MAGIC = 8'hA5;

  function automatic int unsigned frame_len(input int unsigned reg_cnt, input int unsigned mem_words);
    return 1 + reg_cnt + mem_words;
  endfunction

endpackage

// File: rtl/probe_period_timer.sv
// rtl/probe_period_timer.sv - snapshot request generation and overrun detection
module probe_period_timer #(
  parameter int unsigned PROBE_PERIOD = 20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  input  logic mode_i,
  input  logic trigger_i,
  input  logic busy_i,
  output logic start_o,
  output logic overrun_o
);

  localparam int unsigned CW = (PROBE_PERIOD > 2) ? $clog2(PROBE_PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          overrun_q, overrun_d;
  logic          wrap;
  logic          req;

  assign wrap = (cnt_q == CW'(PROBE_PERIOD - 1));
  assign req  = enable_i && (mode_i ? trigger_i : wrap);

  always_comb begin
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    if (enable_i) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
    end
    // busy covers the final-handshake cycle too, so a request there is dropped
    if (req && busy_i) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign start_o   = req && !busy_i;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/dbg_snapshot_streamer.sv
// rtl/dbg_snapshot_streamer.sv - dumps register file and a RAM window as a framed word stream
module dbg_snapshot_streamer
  import dbg_snapshot_pkg::*;
#(
  parameter int unsigned     XLEN          = 32,
  parameter int unsigned     REG_CNT       = 32,
  parameter logic [XLEN-1:0] MEM_WIN_LO    = 32'h7FEC,
  parameter int unsigned     MEM_WIN_WORDS = 8,
  parameter int unsigned     PROBE_PERIOD  = 20,
  parameter int unsigned     CHECK_REG     = 31,
  parameter logic [XLEN-1:0] CHECK_VAL     = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  input  logic            i_mode,
  input  logic            i_trigger,
  output logic [4:0]      o_reg_addr,
  input  logic [XLEN-1:0] i_reg_data,
  output logic            o_mem_rd_en,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic [XLEN-1:0] i_mem_data,
  output logic            o_stream_valid,
  output logic [XLEN-1:0] o_stream_data,
  output logic            o_stream_last,
  input  logic            i_stream_ready,
  output logic            o_busy,
  output logic [15:0]     o_snap_cnt,
  output logic            o_check_fail,
  output logic            o_overrun
);

  localparam int unsigned RI_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;
  localparam int unsigned MI_W = (MEM_WIN_WORDS > 1) ? $clog2(MEM_WIN_WORDS) : 1;

  state_e            state_q, state_d;
  logic [RI_W-1:0]   reg_idx_q, reg_idx_d;
  logic [MI_W-1:0]   mem_idx_q, mem_idx_d;
  logic [XLEN-1:0]   data_q, data_d;
  logic              fresh_q, fresh_d;
  logic [15:0]       snap_cnt_q, snap_cnt_d;
  logic              check_fail_q, check_fail_d;
  logic              start;
  logic              hs;
  logic              reg_last;
  logic              mem_last;

  probe_period_timer #(
    .PROBE_PERIOD(PROBE_PERIOD)
  ) u_timer (
    .clk_i    (i_clk),
    .rst_i    (i_rst),
    .enable_i (i_enable),
    .mode_i   (i_mode),
    .trigger_i(i_trigger),
    .busy_i   (o_busy),
    .start_o  (start),
    .overrun_o(o_overrun)
  );

  assign o_busy         = (state_q != ST_IDLE);
  assign o_stream_valid = (state_q == ST_HDR) || (state_q == ST_REG_OUT) || (state_q == ST_MEM_OUT);
  assign hs             = o_stream_valid && i_stream_ready;
  assign reg_last       = (reg_idx_q == RI_W'(REG_CNT - 1));
  assign mem_last       = (mem_idx_q == MI_W'(MEM_WIN_WORDS - 1));
  assign o_stream_last  = (state_q == ST_MEM_OUT) && mem_last;

  assign o_reg_addr  = (state_q == ST_REG_RD) ? 5'(reg_idx_q) : 5'd0;
  assign o_mem_rd_en = (state_q == ST_MEM_RD);
  assign o_mem_addr  = o_mem_rd_en ? MEM_WIN_LO + XLEN'(mem_idx_q) * XLEN'(XLEN / 8) : '0;

  // First OUT cycle forwards the read port directly; data_q holds it for any stall
  always_comb begin
    o_stream_data = data_q;
    if (fresh_q) begin
      o_stream_data = (state_q == ST_MEM_OUT) ? i_mem_data : i_reg_data;
    end
  end

  always_comb begin
    state_d      = state_q;
    reg_idx_d    = reg_idx_q;
    mem_idx_d    = mem_idx_q;
    data_d       = data_q;
    fresh_d      = 1'b0;
    snap_cnt_d   = snap_cnt_q;
    check_fail_d = check_fail_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d   = ST_HDR;
          reg_idx_d = '0;
          mem_idx_d = '0;
          data_d    = {SNAP_MAGIC, {(XLEN - 24){1'b0}}, snap_cnt_q};
        end
      end
      ST_HDR: begin
        if (hs) state_d = ST_REG_RD;
      end
      ST_REG_RD: begin
        state_d = ST_REG_OUT;
        fresh_d = 1'b1;
      end
      ST_REG_OUT: begin
        if (fresh_q) begin
          data_d = i_reg_data;
          if (reg_idx_q == RI_W'(CHECK_REG) && i_reg_data != CHECK_VAL) check_fail_d = 1'b1;
        end
        if (hs) begin
          if (reg_last) begin
            state_d = ST_MEM_RD;
          end else begin
            reg_idx_d = reg_idx_q + 1'b1;
            state_d   = ST_REG_RD;
          end
        end
      end
      ST_MEM_RD: begin
        state_d = ST_MEM_OUT;
        fresh_d = 1'b1;
      end
      ST_MEM_OUT: begin
        if (fresh_q) data_d = i_mem_data;
        if (hs) begin
          if (mem_last) begin
            state_d    = ST_IDLE;
            snap_cnt_d = snap_cnt_q + 16'd1;
          end else begin
            mem_idx_d = mem_idx_q + 1'b1;
            state_d   = ST_MEM_RD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_IDLE;
      reg_idx_q    <= '0;
      mem_idx_q    <= '0;
      data_q       <= '0;
      fresh_q      <= 1'b0;
      snap_cnt_q   <= '0;
      check_fail_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      reg_idx_q    <= reg_idx_d;
      mem_idx_q    <= mem_idx_d;
      data_q       <= data_d;
      fresh_q      <= fresh_d;
      snap_cnt_q   <= snap_cnt_d;
      check_fail_q <= check_fail_d;
    end
  end

  assign o_snap_cnt   = snap_cnt_q;
  assign o_check_fail = check_fail_q;

endmodule

// File: tb/tb_dbg_snapshot_streamer.sv
// tb/tb_dbg_snapshot_streamer.sv - scoreboard bench for dbg_snapshot_streamer
module tb_dbg_snapshot_streamer;
  import dbg_snapshot_pkg::*;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_enable = 1'b0;
  logic        i_mode = 1'b0;
  logic        i_trigger = 1'b0;
  logic [4:0]  o_reg_addr;
  logic [31:0] i_reg_data = '0;
  logic        o_mem_rd_en;
  logic [31:0] o_mem_addr;
  logic [31:0] i_mem_data = '0;
  logic        o_stream_valid;
  logic [31:0] o_stream_data;
  logic        o_stream_last;
  logic        i_stream_ready = 1'b1;
  logic        o_busy;
  logic [15:0] o_snap_cnt;
  logic        o_check_fail;
  logic        o_overrun;

  int errors = 0;
  int checks = 0;

  logic [31:0] regs [32];
  logic [31:0] exp_data_q [$];
  logic        exp_last_q [$];
  int          words_seen = 0;
  int          frame_words = 0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_data;
  logic        stall_last;

  localparam logic [31:0] MEM_EXP [8] = '{32'h7FEC, 32'h7FF0, 32'h7FF4, 32'h7FF8,
                                          32'h7FFC, 32'h8000, 32'h8004, 32'h8008};

  dbg_snapshot_streamer dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_enable      (i_enable),
    .i_mode        (i_mode),
    .i_trigger     (i_trigger),
    .o_reg_addr    (o_reg_addr),
    .i_reg_data    (i_reg_data),
    .o_mem_rd_en   (o_mem_rd_en),
    .o_mem_addr    (o_mem_addr),
    .i_mem_data    (i_mem_data),
    .o_stream_valid(o_stream_valid),
    .o_stream_data (o_stream_data),
    .o_stream_last (o_stream_last),
    .i_stream_ready(i_stream_ready),
    .o_busy        (o_busy),
    .o_snap_cnt    (o_snap_cnt),
    .o_check_fail  (o_check_fail),
    .o_overrun     (o_overrun)
  );

  always #5 clk = ~clk;

  // Synchronous-read register file and RAM (RAM word content = its byte address)
  always @(posedge clk) begin
    i_reg_data <= regs[o_reg_addr];
    if (o_mem_rd_en) i_mem_data <= o_mem_addr;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_frame(input logic [15:0] cnt, input logic [31:0] r31);
    exp_data_q.push_back({8'hA5, 8'h00, cnt});
    exp_last_q.push_back(1'b0);
    for (int i = 0; i < 32; i++) begin
      exp_data_q.push_back((i == 31) ? r31 : 32'(i));
      exp_last_q.push_back(1'b0);
    end
    for (int k = 0; k < 8; k++) begin
      exp_data_q.push_back(MEM_EXP[k]);
      exp_last_q.push_back(k == 7);
    end
  endtask

  always @(negedge clk) begin
    if (i_rst) begin
      stall_prev  = 1'b0;
      frame_words = 0;
      exp_data_q.delete();
      exp_last_q.delete();
    end else begin
      if (stall_prev) begin
        chk("hold_valid", {31'd0, o_stream_valid}, 32'd1);
        chk("hold_data", o_stream_data, stall_data);
        chk("hold_last", {31'd0, o_stream_last}, {31'd0, stall_last});
      end
      if (o_stream_valid && i_stream_ready) begin
        if (exp_data_q.size() == 0) begin
          chk("unexpected_word", o_stream_data, 32'hDEAD_BEEF ^ o_stream_data ^ 32'h1);
        end else begin
          logic [31:0] ed;
          logic        el;
          ed = exp_data_q.pop_front();
          el = exp_last_q.pop_front();
          chk($sformatf("word%0d_data", frame_words), o_stream_data, ed);
          chk($sformatf("word%0d_last", frame_words), {31'd0, o_stream_last}, {31'd0, el});
          frame_words++;
          words_seen++;
          if (el) begin
            chk("frame_length", 32'(frame_words), 32'(frame_len(32, 8)));
            frame_words = 0;
          end
        end
      end
      stall_prev = o_stream_valid && !i_stream_ready;
      stall_data = o_stream_data;
      stall_last = o_stream_last;
    end
  end

  // Runs cycles until o_snap_cnt reaches target; optional ready toggling, a second
  // trigger after trig_at words, or an asynchronous reset after rst_at words.
  task automatic run_frame(input logic [15:0] target, input bit toggle, input int trig_at, input int rst_at);
    int  n = 0;
    int  base = words_seen;
    bit  fired = 1'b0;
    bit  done = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (toggle) i_stream_ready = ~i_stream_ready;
      i_trigger = 1'b0;
      if (trig_at >= 0 && !fired && (words_seen - base) >= trig_at) begin
        i_trigger = 1'b1;
        fired = 1'b1;
      end
      if (rst_at >= 0 && (words_seen - base) >= rst_at) begin
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'd0, o_stream_valid}, 32'd0);
        chk("rst_async_snap_cnt", {16'd0, o_snap_cnt}, 32'd0);
        chk("rst_async_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_async_overrun", {31'd0, o_overrun}, 32'd0);
        done = 1'b1;
      end else if (rst_at < 0 && o_snap_cnt == target) begin
        done = 1'b1;
      end
    end
    i_trigger = 1'b0;
    if (!done) chk("frame_timeout", {16'd0, o_snap_cnt}, {16'd0, target});
  endtask

  task automatic pulse_trigger();
    @(posedge clk);
    #1 i_trigger = 1'b1;
    @(posedge clk);
    #1 i_trigger = 1'b0;
  endtask

  initial begin
    int cyc;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i);
    regs[31] = 32'd2;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, o_stream_valid}, 32'd0);
    chk("reset_data", o_stream_data, 32'd0);
    chk("reset_last", {31'd0, o_stream_last}, 32'd0);
    chk("reset_busy", {31'd0, o_busy}, 32'd0);
    chk("reset_snap_cnt", {16'd0, o_snap_cnt}, 32'd0);
    chk("reset_check_fail", {31'd0, o_check_fail}, 32'd0);
    chk("reset_overrun", {31'd0, o_overrun}, 32'd0);
    chk("reset_mem_rd_en", {31'd0, o_mem_rd_en}, 32'd0);
    chk("reset_mem_addr", o_mem_addr, 32'd0);
    chk("reset_reg_addr", {27'd0, o_reg_addr}, 32'd0);
    i_rst = 1'b0;

    // Periodic mode: two back-to-back frames at full throughput
    push_frame(16'd0, 32'd2);
    push_frame(16'd1, 32'd2);
    i_enable = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(posedge clk);
      cyc++;
      #1;
      if (o_stream_valid) break;
    end
    chk("first_header_latency", 32'(cyc), 32'd20);
    run_frame(16'd2, 1'b0, -1, -1);
    i_enable = 1'b0;
    chk("periodic_snap_cnt", {16'd0, o_snap_cnt}, 32'd2);
    chk("periodic_overrun", {31'd0, o_overrun}, 32'd1);
    chk("periodic_check_ok", {31'd0, o_check_fail}, 32'd0);

    // Periodic mode with ready toggling every cycle
    push_frame(16'd2, 32'd2);
    i_enable = 1'b1;
    run_frame(16'd3, 1'b1, -1, -1);
    i_enable = 1'b0;
    i_stream_ready = 1'b1;
    chk("toggle_snap_cnt", {16'd0, o_snap_cnt}, 32'd3);
    chk("toggle_queue_empty", 32'(exp_data_q.size()), 32'd0);

    // Triggered frame aborted by reset after 10 words
    i_mode = 1'b1;
    i_enable = 1'b1;
    push_frame(16'd3, 32'd2);
    pulse_trigger();
    run_frame(16'hFFFF, 1'b0, -1, 10);
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;

    // Triggered frame, failing check register, second trigger mid-frame
    regs[31] = 32'd3;
    push_frame(16'd0, 32'd3);
    pulse_trigger();
    run_frame(16'd1, 1'b0, 5, -1);
    chk("trig_overrun", {31'd0, o_overrun}, 32'd1);
    chk("trig_check_fail", {31'd0, o_check_fail}, 32'd1);
    chk("trig_snap_cnt", {16'd0, o_snap_cnt}, 32'd1);
    repeat (60) @(posedge clk);
    #1;
    chk("trig_busy_after", {31'd0, o_busy}, 32'd0);
    chk("trig_queue_empty", 32'(exp_data_q.size()), 32'd0);

    // Passing check value afterwards leaves the sticky flag set
    regs[31] = 32'd2;
    push_frame(16'd1, 32'd2);
    pulse_trigger();
    run_frame(16'd2, 1'b0, -1, -1);
    chk("check_fail_sticky", {31'd0, o_check_fail}, 32'd1);
    chk("final_snap_cnt", {16'd0, o_snap_cnt}, 32'd2);
    repeat (10) @(posedge clk);
    #1;
    chk("final_queue_empty", 32'(exp_data_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
